// File: rtl/cart_pkg.sv
// Shared encodings for the cart engine: command ops, response status, FSM states.
// Pure definitions, no logic; imported by the engine and its accumulate stage.
package cart_pkg;

    typedef enum logic [1:0] {
        OP_ADD    = 2'd0,
        OP_REMOVE = 2'd1,
        OP_UPDATE = 2'd2,
        OP_CLEAR  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_FULL      = 2'd1,
        ST_NOT_FOUND = 2'd2,
        ST_SAT       = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEARCH = 3'd1,
        S_APPLY  = 3'd2,
        S_RECALC = 3'd3,
        S_RESP   = 3'd4
    } state_e;

    // Width needed to hold a count from 0 to n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Width needed to index n slots (n >= 2).
    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/cart_line_mac.sv
// One line-item step of the cart total: price*qty added into a saturating accumulator.
// Combinational, zero latency; no flow control. The accumulator MSB is a sticky overflow flag.
module cart_line_mac #(
    parameter int PRICE_W = 16,
    parameter int QTY_W   = 8,
    parameter int TOTAL_W = 32
) (
    input  logic [TOTAL_W:0]   acc_in,
    input  logic [PRICE_W-1:0] price,
    input  logic [QTY_W-1:0]   qty,
    input  logic               en,
    output logic [TOTAL_W:0]   acc_out
);

    localparam int PW = PRICE_W + QTY_W;
    localparam int SW = ((TOTAL_W > PW) ? TOTAL_W : PW) + 2;

    logic [PW-1:0] prod;
    logic [SW-1:0] sum;

    assign prod = PW'(price) * PW'(qty);
    assign sum  = SW'(acc_in[TOTAL_W-1:0]) + SW'(prod);

    // Once the flag is set the accumulator stays pinned at all-ones.
    always_comb begin
        acc_out = acc_in;
        if (en) begin
            if (acc_in[TOTAL_W] || ((sum >> TOTAL_W) != '0)) begin
                acc_out = {1'b1, {TOTAL_W{1'b1}}};
            end else begin
                acc_out = {1'b0, sum[TOTAL_W-1:0]};
            end
        end
    end

endmodule

// File: rtl/cart_engine.sv
// Multi-slot shopping cart: ADD/REMOVE/UPDATE/CLEAR with sequential saturating total recompute.
// Latency 2*SLOTS+2 cycles accept-to-rsp_valid; cmd_ready only in IDLE so busy-time commands stall.
// CART_DISCOUNT_EN adds disc_q8 input and net_total output (total less a Q0.8 discount).
module cart_engine
    import cart_pkg::*;
#(
    parameter int SLOTS   = 8,
    parameter int ID_W    = 8,
    parameter int PRICE_W = 16,
    parameter int QTY_W   = 8,
    parameter int TOTAL_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [ID_W-1:0]           cmd_id,
    input  logic [PRICE_W-1:0]        cmd_price,
    input  logic [QTY_W-1:0]          cmd_qty,
    output logic                      rsp_valid,
    output logic [1:0]                rsp_status,
    output logic [TOTAL_W-1:0]        total,
    output logic                      total_valid,
`ifdef CART_DISCOUNT_EN
    input  logic [7:0]                disc_q8,
    output logic [TOTAL_W-1:0]        net_total,
`endif
    output logic [cnt_w(SLOTS)-1:0]   item_count
);

    localparam int IW = idx_w(SLOTS);
    localparam int CW = cnt_w(SLOTS);

    state_e               state, state_n;
    logic [IW-1:0]        idx;
    logic                 last;

    op_e                  op_q;
    logic [ID_W-1:0]      id_q;
    logic [PRICE_W-1:0]   price_q;
    logic [QTY_W-1:0]     qty_q;
    status_e              status_q;

    logic                 match_found, free_found;
    logic [IW-1:0]        match_idx, free_idx;

    logic [SLOTS-1:0]     slot_vld, n_vld;
    logic [ID_W-1:0]      slot_id    [SLOTS];
    logic [PRICE_W-1:0]   slot_price [SLOTS];
    logic [QTY_W-1:0]     slot_qty   [SLOTS];
    logic [ID_W-1:0]      n_id       [SLOTS];
    logic [PRICE_W-1:0]   n_price    [SLOTS];
    logic [QTY_W-1:0]     n_qty      [SLOTS];
    status_e              n_status;
    logic [CW-1:0]        n_count;
    logic [QTY_W:0]       qty_sum;

    logic [TOTAL_W:0]     acc, mac_out;
    logic [TOTAL_W-1:0]   sat_total;

    assign cmd_ready = (state == S_IDLE);
    assign last      = (idx == IW'(SLOTS - 1));
    assign sat_total = acc[TOTAL_W] ? {TOTAL_W{1'b1}} : acc[TOTAL_W-1:0];

    cart_line_mac #(
        .PRICE_W (PRICE_W),
        .QTY_W   (QTY_W),
        .TOTAL_W (TOTAL_W)
    ) u_mac (
        .acc_in  (acc),
        .price   (slot_price[idx]),
        .qty     (slot_qty[idx]),
        .en      (slot_vld[idx]),
        .acc_out (mac_out)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:   if (cmd_valid) state_n = S_SEARCH;
            S_SEARCH: if (last)      state_n = S_APPLY;
            S_APPLY:                 state_n = S_RECALC;
            S_RECALC: if (last)      state_n = S_RESP;
            S_RESP:                  state_n = S_IDLE;
            default:                 state_n = S_IDLE;
        endcase
    end

    // Post-command slot image; committed in APPLY.
    always_comb begin
        n_vld    = slot_vld;
        n_id     = slot_id;
        n_price  = slot_price;
        n_qty    = slot_qty;
        n_status = ST_OK;
        qty_sum  = {1'b0, slot_qty[match_idx]} + {1'b0, qty_q};
        unique case (op_q)
            OP_ADD: begin
                if (qty_q != '0) begin
                    if (match_found) begin
                        n_price[match_idx] = price_q;
                        n_qty[match_idx]   = qty_sum[QTY_W] ? {QTY_W{1'b1}} : qty_sum[QTY_W-1:0];
                    end else if (free_found) begin
                        n_vld[free_idx]   = 1'b1;
                        n_id[free_idx]    = id_q;
                        n_price[free_idx] = price_q;
                        n_qty[free_idx]   = qty_q;
                    end else begin
                        n_status = ST_FULL;
                    end
                end
            end
            OP_REMOVE: begin
                if (match_found) n_vld[match_idx] = 1'b0;
                else             n_status = ST_NOT_FOUND;
            end
            OP_UPDATE: begin
                if (match_found) begin
                    n_qty[match_idx] = qty_q;
                    if (qty_q == '0) n_vld[match_idx] = 1'b0;
                end else begin
                    n_status = ST_NOT_FOUND;
                end
            end
            OP_CLEAR: n_vld = '0;
            default: ;
        endcase
        n_count = '0;
        for (int i = 0; i < SLOTS; i++) n_count = n_count + CW'(n_vld[i]);
    end

`ifdef CART_DISCOUNT_EN
    logic [7:0]           disc_q;
    logic [TOTAL_W+7:0]   disc_prod;
    assign disc_prod = (TOTAL_W+8)'(sat_total) * (TOTAL_W+8)'(disc_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            disc_q    <= '0;
            net_total <= '0;
        end else begin
            if (state == S_IDLE && cmd_valid) disc_q <= disc_q8;
            if (state == S_RESP) net_total <= sat_total - disc_prod[TOTAL_W+7:8];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            idx         <= '0;
            op_q        <= OP_ADD;
            id_q        <= '0;
            price_q     <= '0;
            qty_q       <= '0;
            status_q    <= ST_OK;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            acc         <= '0;
            slot_vld    <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                slot_id[i]    <= '0;
                slot_price[i] <= '0;
                slot_qty[i]   <= '0;
            end
            rsp_valid   <= 1'b0;
            rsp_status  <= ST_OK;
            total       <= '0;
            total_valid <= 1'b1;
            item_count  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q        <= op_e'(cmd_op);
                        id_q        <= cmd_id;
                        price_q     <= cmd_price;
                        qty_q       <= cmd_qty;
                        idx         <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        total_valid <= 1'b0;
                    end
                end
                S_SEARCH: begin
                    if (slot_vld[idx] && slot_id[idx] == id_q && !match_found) begin
                        match_found <= 1'b1;
                        match_idx   <= idx;
                    end
                    if (!slot_vld[idx] && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= idx;
                    end
                    idx <= last ? '0 : idx + 1'b1;
                end
                S_APPLY: begin
                    slot_vld   <= n_vld;
                    slot_id    <= n_id;
                    slot_price <= n_price;
                    slot_qty   <= n_qty;
                    status_q   <= n_status;
                    item_count <= n_count;
                    acc        <= '0;
                    idx        <= '0;
                end
                S_RECALC: begin
                    acc <= mac_out;
                    idx <= last ? '0 : idx + 1'b1;
                end
                S_RESP: begin
                    rsp_valid   <= 1'b1;
                    total       <= sat_total;
                    total_valid <= 1'b1;
                    rsp_status  <= (status_q != ST_OK) ? status_q
                                 : (acc[TOTAL_W] ? ST_SAT : ST_OK);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cart_engine.md
Name: cart_engine

Overview:
Parametrised multi-slot shopping-cart engine with a command handshake.
- Holds up to SLOTS line items, each keyed by an item ID with its own valid bit.
- Executes ADD, REMOVE, UPDATE and CLEAR commands one at a time.
- Recomputes the cart total sequentially, one slot per cycle, with saturation detection.
- Sits between the checkout command source and the display/billing logic.

Parameters:
SLOTS, 8, number of line-item slots (>=2)
ID_W, 8, item ID width
PRICE_W, 16, unit price width
QTY_W, 8, quantity width
TOTAL_W, 32, cart total width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  engine can accept a command
cmd_op  input  2  0=ADD 1=REMOVE 2=UPDATE 3=CLEAR
cmd_id  input  ID_W  item ID
cmd_price  input  PRICE_W  unit price (ADD only)
cmd_qty  input  QTY_W  quantity (ADD) or new quantity (UPDATE)
rsp_valid  output  1  one-cycle completion pulse
rsp_status  output  2  0=OK 1=FULL 2=NOT_FOUND 3=SAT
total  output  TOTAL_W  cart total
total_valid  output  1  total reflects all completed commands
item_count  output  $clog2(SLOTS+1)  number of valid slots

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: all slots invalid (ID/price/qty = 0), FSM in IDLE, cmd_ready=1, rsp_valid=0, rsp_status=0, total=0, total_valid=1, item_count=0.
- Handshake:
  - Command accepted on a clk edge with cmd_valid && cmd_ready.
  - cmd_ready is high only in IDLE; a command presented while busy is stalled, not dropped.
  - Command fields are latched at accept.
- FSM states: IDLE -> SEARCH -> APPLY -> RECALC -> RESP -> IDLE.
  - SEARCH: exactly SLOTS cycles, one slot examined per cycle. Records the lowest-index valid slot whose ID matches and the lowest-index free slot. CLEAR also runs SEARCH, so latency is fixed.
  - APPLY: 1 cycle; performs the slot update and recomputes item_count.
  - RECALC: SLOTS cycles. Accumulates price*qty for each valid slot into a TOTAL_W+1 accumulator; the product is PRICE_W+QTY_W bits, zero-extended.
  - RESP: 1 cycle; rsp_valid=1, total and rsp_status updated.
- Latency: rsp_valid is asserted 2*SLOTS+2 cycles after the accept edge. total_valid is low from accept until RESP, inclusive of the accept cycle's following edge.
- ADD:
  - ID matches a valid slot: qty = min(old+cmd_qty, 2^QTY_W-1) and price is overwritten.
  - No match, free slot exists: allocate the lowest free slot.
  - No match, no free slot: FULL, no state change.
  - cmd_qty=0: no-op, status OK.
- REMOVE: a match invalidates the slot; no match gives NOT_FOUND.
- UPDATE: a match sets qty=cmd_qty, and cmd_qty=0 invalidates the slot; no match gives NOT_FOUND.
- CLEAR: invalidates all slots; always OK.
- Saturation: if the accumulator exceeds 2^TOTAL_W-1, total = all-ones and status = SAT; the operation itself is still applied. FULL and NOT_FOUND take precedence over SAT.
- Reset mid-operation: the in-flight command is discarded with no rsp_valid, and the next cycle is in reset state.

Optional Feature:
CART_DISCOUNT_EN
- Defined:
  - Adds input disc_q8 [7:0] and output net_total [TOTAL_W-1:0].
  - disc_q8 is sampled at accept.
  - In RESP, net_total = total - ((total*disc_q8) >> 8), computed from the saturated total.
  - net_total resets to 0.
- Undefined: neither port exists and behaviour is otherwise identical.

Decomposition:
- Package cart_pkg holds the op encoding, status encoding and FSM state enum, plus helper constant functions for count width.
- One sub-module, cart_line_mac:
  - Combinational price*qty product.
  - Saturating accumulate step with a valid-gating input.
  - Used by RECALC.

Test Plan:
1. Reset, then ADD id=1 price=100 qty=1 -> rsp_valid 18 cycles after accept, OK, total=100, item_count=1.
2. ADD id=2 price=50 qty=3, then UPDATE id=1 qty=2 -> total=350; then UPDATE id=1 qty=0 -> total=150, item_count=1.
3. Fill 8 distinct IDs, then ADD id=9 -> FULL, total unchanged. REMOVE id=42 -> NOT_FOUND. CLEAR -> total=0, item_count=0.
4. ADD id=5 qty=200, then ADD id=5 qty=100 -> qty saturates at 255, single slot used.
5. TOTAL_W=24: ADD two IDs each price=65535 qty=255 -> second response SAT, total=0xFFFFFF.
6. Assert reset during RECALC -> no rsp_valid, total=0, cmd_ready=1. With CART_DISCOUNT_EN, disc_q8=64 and total=400 -> net_total=300.
